// File: rtl/fetch_ctl_pkg.sv
// Shared fetch/decode definitions: redirect source selection with jar > jump > branch priority.
package fetch_ctl_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JAR = 2'd3
  } redir_sel_e;

  localparam logic [1:0] QFULL = 2'd2;

  function automatic redir_sel_e redir_select(input logic jar, input logic jump, input logic br_taken);
    redir_sel_e sel;
    if (jar)
      sel = SEL_JAR;
    else if (jump)
      sel = SEL_J;
    else if (br_taken)
      sel = SEL_BR;
    else
      sel = SEL_SEQ;
    return sel;
  endfunction

endpackage

// File: rtl/fetch_ctl_queue.sv
// Two-entry {pc, instr} FIFO between instruction memory and decode.
// flush_young trims the queue to its oldest surviving entry after this cycle's pop.
module fetch_queue #(
  parameter int PCW = 30
) (
  input  logic           clock,
  input  logic           rst,
  input  logic           i_push,
  input  logic           i_pop,
  input  logic           i_flush_young,
  input  logic [PCW-1:0] i_push_pc,
  input  logic [31:0]    i_push_instr,
  output logic [1:0]     o_count,
  output logic [PCW-1:0] o_head_pc,
  output logic [31:0]    o_head_instr
);

  logic [PCW-1:0] r_pc0, r_pc1;
  logic [31:0]    r_in0, r_in1;
  logic [1:0]     r_count;

  logic [1:0]     w_rem;
  logic [1:0]     w_count_n;
  logic [PCW-1:0] w_pc0, w_pc1;
  logic [31:0]    w_in0, w_in1;

  always_comb begin
    w_rem = r_count - {1'b0, i_pop};
    if (i_flush_young && (w_rem > 2'd1))
      w_rem = 2'd1;
    w_pc0 = i_pop ? r_pc1 : r_pc0;
    w_in0 = i_pop ? r_in1 : r_in0;
    w_pc1 = r_pc1;
    w_in1 = r_in1;
    if (i_push) begin
      if (w_rem == 2'd0) begin
        w_pc0 = i_push_pc;
        w_in0 = i_push_instr;
      end else begin
        w_pc1 = i_push_pc;
        w_in1 = i_push_instr;
      end
    end
    w_count_n = w_rem + {1'b0, i_push};
  end

  // head is registered so decode sees data the cycle after completion
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
      r_pc0   <= '0;
      r_pc1   <= '0;
      r_in0   <= '0;
      r_in1   <= '0;
    end else begin
      r_count <= w_count_n;
      r_pc0   <= w_pc0;
      r_pc1   <= w_pc1;
      r_in0   <= w_in0;
      r_in1   <= w_in1;
    end
  end

  assign o_count      = r_count;
  assign o_head_pc    = r_pc0;
  assign o_head_instr = r_in0;

endmodule

// File: rtl/fetch_ctl.sv
// Fetch-stage controller: owns the fetch PC, issues imem requests and applies
// branch/jump/jar redirects with a single architectural delay slot.
module fetch_ctl
  import fetch_ctl_pkg::*;
#(
  parameter int             PCW      = 30,
  parameter logic [PCW-1:0] RESET_PC = '0
) (
  input  logic           clock,
  input  logic           rst,
  input  logic           br_taken,
  input  logic [PCW-1:0] br_target,
  input  logic           jump,
  input  logic [PCW-1:0] jump_target,
  input  logic           jar,
  input  logic [PCW-1:0] jar_target,
  input  logic           id_stall,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_ready,
  input  logic [31:0]    imem_rdata,
  output logic           if_valid,
  output logic [31:0]    if_instr,
  output logic [PCW-1:0] if_pc,
  output logic [PCW-1:0] if_pc_plus2
);

  logic [PCW-1:0] r_fetch_pc;
  logic           r_pend_v;
  logic [PCW-1:0] r_pend_tgt;
  logic           r_drop;

  logic [1:0]     w_count;
  logic [PCW-1:0] w_head_pc;
  logic [31:0]    w_head_instr;
  logic           w_done, w_pop, w_redir, w_live, w_push, w_flush;
  logic [1:0]     w_rem;
  redir_sel_e     w_sel;
  logic [PCW-1:0] w_target;
  logic [PCW-1:0] w_fetch_n, w_pend_tgt_n;
  logic           w_pend_v_n, w_drop_n;

  // The fetch PC never moves while a request is held, so issuing only below
  // a full queue also guarantees every completion has a free slot.
  assign imem_req  = ~rst & (w_count != QFULL);
  assign imem_addr = r_fetch_pc;

  assign w_done  = imem_req & imem_ready;
  assign w_pop   = if_valid & ~id_stall;
  assign w_sel   = redir_select(jar, jump, br_taken);
  assign w_redir = w_pop & (w_sel != SEL_SEQ);
  assign w_rem   = w_count - {1'b0, w_pop};
  assign w_live  = imem_req & ~r_drop;

  always_comb begin
    case (w_sel)
      SEL_JAR: w_target = jar_target;
      SEL_J:   w_target = jump_target;
      SEL_BR:  w_target = br_target;
      default: w_target = r_fetch_pc;
    endcase
  end

  always_comb begin
    w_fetch_n    = r_fetch_pc;
    w_pend_v_n   = r_pend_v;
    w_pend_tgt_n = r_pend_tgt;
    w_drop_n     = r_drop;
    w_push       = 1'b0;
    w_flush      = 1'b0;

    if (w_done) begin
      if (r_drop)
        w_drop_n = 1'b0;
      else
        w_push = 1'b1;
      if (r_pend_v) begin
        w_fetch_n  = r_pend_tgt;
        w_pend_v_n = 1'b0;
      end else begin
        w_fetch_n = r_fetch_pc + PCW'(1);
      end
    end

    // Oldest surviving instruction (queue first, then live request) is the
    // delay slot; anything younger is discarded.
    if (w_redir) begin
      w_flush = 1'b1;
      if ((w_rem == 2'd0) && !w_live) begin
        w_pend_v_n   = 1'b1;
        w_pend_tgt_n = w_target;
      end else begin
        if ((w_rem != 2'd0) && w_live) begin
          if (w_done)
            w_push = 1'b0;
          else
            w_drop_n = 1'b1;
        end
        if (imem_req && !w_done) begin
          w_pend_v_n   = 1'b1;
          w_pend_tgt_n = w_target;
        end else begin
          w_fetch_n  = w_target;
          w_pend_v_n = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_pend_v   <= 1'b0;
      r_pend_tgt <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_fetch_pc <= w_fetch_n;
      r_pend_v   <= w_pend_v_n;
      r_pend_tgt <= w_pend_tgt_n;
      r_drop     <= w_drop_n;
    end
  end

  fetch_queue #(.PCW(PCW)) u_queue (
    .clock         (clock),
    .rst           (rst),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_flush_young (w_flush),
    .i_push_pc     (imem_addr),
    .i_push_instr  (imem_rdata),
    .o_count       (w_count),
    .o_head_pc     (w_head_pc),
    .o_head_instr  (w_head_instr)
  );

  assign if_valid    = (w_count != 2'd0);
  assign if_instr    = w_head_instr;
  assign if_pc       = w_head_pc;
  assign if_pc_plus2 = w_head_pc + PCW'(2);

endmodule

// File: tb/tb_fetch_ctl.sv
// Bench for fetch_ctl: variable-latency memory responder plus a decode-side
// model that predicts the popped instruction stream from delay-slot rules.
module tb_fetch_ctl;
  localparam int PCW = 30;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           rst = 1'b1;
  logic           br_taken = 1'b0, jump = 1'b0, jar = 1'b0, id_stall = 1'b0;
  logic [PCW-1:0] br_target = '0, jump_target = '0, jar_target = '0;
  logic           imem_req, imem_ready, if_valid;
  logic [PCW-1:0] imem_addr, if_pc, if_pc_plus2;
  logic [31:0]    imem_rdata, if_instr;

  int checks = 0;
  int errors = 0;

  int wcnt = 0;
  int lat = 0;
  int fixed_lat = 0;
  bit rand_lat = 1'b0;
  bit force_rdy = 1'b0;

  logic [PCW-1:0] m_exp = '0;
  logic [PCW-1:0] m_tgt = '0;
  bit             m_ds = 1'b0;
  logic [PCW-1:0] pop_log[$];
  int             pops = 0;

  function automatic logic [31:0] mem_word(input logic [PCW-1:0] a);
    return {2'b10, a} ^ 32'h1357_9BDF;
  endfunction

  assign imem_ready = force_rdy | (imem_req && (wcnt >= lat));
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clock) begin
    if (imem_req && imem_ready) begin
      wcnt <= 0;
      lat  <= rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    end else if (imem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  fetch_ctl dut (
    .clock       (clock),
    .rst         (rst),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .jar         (jar),
    .jar_target  (jar_target),
    .id_stall    (id_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus2 (if_pc_plus2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: sets decode inputs for the coming rising edge and
  // scores the head if it is consumed.
  task automatic drive(input bit st, input bit jr, input logic [PCW-1:0] jrt,
                       input bit jp, input logic [PCW-1:0] jpt,
                       input bit b, input logic [PCW-1:0] bt);
    id_stall = st;
    jar = jr;      jar_target = jrt;
    jump = jp;     jump_target = jpt;
    br_taken = b;  br_target = bt;
    if (if_valid && !st) begin
      chk("pop_pc", 64'(if_pc), 64'(m_exp));
      chk("pop_instr", 64'(if_instr), 64'(mem_word(if_pc)));
      chk("pop_pc_plus2", 64'(if_pc_plus2), 64'(PCW'(if_pc + PCW'(2))));
      pop_log.push_back(if_pc);
      pops++;
      if (m_ds) begin
        m_exp = m_tgt;
        m_ds  = 1'b0;
      end else begin
        m_exp = PCW'(if_pc + PCW'(1));
      end
      if (jr || jp || b) begin
        m_ds  = 1'b1;
        m_tgt = jr ? jrt : (jp ? jpt : bt);
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_stall = 1'b0; jar = 1'b0; jump = 1'b0; br_taken = 1'b0;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    m_exp = '0;
    m_ds = 1'b0;
    pop_log.delete();
  endtask

  task automatic wait_head(input logic [PCW-1:0] pc, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (if_valid && if_pc == pc) begin
        found = 1'b1;
        break;
      end
      idle();
    end
    chk(tag, 64'(found), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit             prev_req, prev_rdy, found, saw_bad, st, rd, jr, jp, b;
    logic [PCW-1:0] prev_addr;
    int             last;

    // reset values while rst is held
    repeat (2) @(negedge clock);
    chk("reset_req", 64'(imem_req), 64'(0));
    chk("reset_addr", 64'(imem_addr), 64'(0));
    chk("reset_valid", 64'(if_valid), 64'(0));
    chk("reset_instr", 64'(if_instr), 64'(0));
    chk("reset_pc", 64'(if_pc), 64'(0));
    chk("reset_pc_plus2", 64'(if_pc_plus2), 64'(2));
    rst = 1'b0;
    #1;
    chk("first_req", 64'(imem_req), 64'(1));
    chk("first_addr", 64'(imem_addr), 64'(0));

    // zero-latency memory: one instruction per cycle
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk("tput_addr", 64'(imem_addr), 64'(k));
      chk("tput_valid", 64'(if_valid), 64'(1));
      chk("tput_pc", 64'(if_pc), 64'(k - 1));
      idle();
    end

    // fixed 2-cycle wait: request held 3 cycles, if_valid every 3 cycles
    fixed_lat = 2;
    repeat (8) begin
      @(negedge clock);
      idle();
    end
    last = -1;
    prev_req = 1'b0; prev_rdy = 1'b0; prev_addr = '0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clock);
      if (prev_req && !prev_rdy) begin
        chk("lat_addr_hold", 64'(imem_addr), 64'(prev_addr));
        chk("lat_req_hold", 64'(imem_req), 64'(1));
      end
      if (if_valid) begin
        if (last >= 0) chk("lat_valid_gap", 64'(c - last), 64'(3));
        last = c;
      end
      prev_req = imem_req; prev_rdy = imem_ready; prev_addr = imem_addr;
      idle();
    end
    chk("lat_valid_seen", 64'(last >= 0), 64'(1));

    // decode stall at pc 4: queue fills, requests stop, nothing lost
    fixed_lat = 0;
    do_reset();
    wait_head(PCW'(4), "stall_reach4");
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_pc", 64'(if_pc), 64'(4));
      chk("stall_valid", 64'(if_valid), 64'(1));
      chk("stall_req", 64'(imem_req), 64'(0));
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    end
    pop_log.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      idle();
    end
    chk("stall_release_cnt", 64'(pop_log.size() >= 3), 64'(1));
    if (pop_log.size() >= 3) begin
      chk("stall_release_0", 64'(pop_log[0]), 64'(4));
      chk("stall_release_1", 64'(pop_log[1]), 64'(5));
      chk("stall_release_2", 64'(pop_log[2]), 64'(6));
    end

    // taken branch at pc 8: delay slot 9, then 0x40
    do_reset();
    wait_head(PCW'(8), "br_reach8");
    pop_log.delete();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, PCW'(32'h40));
    saw_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (if_valid && if_pc == PCW'(10)) saw_bad = 1'b1;
      idle();
    end
    chk("br_seen10", 64'(saw_bad), 64'(0));
    chk("br_log_cnt", 64'(pop_log.size() >= 3), 64'(1));
    if (pop_log.size() >= 3) begin
      chk("br_seq_0", 64'(pop_log[0]), 64'(8));
      chk("br_seq_1", 64'(pop_log[1]), 64'(9));
      chk("br_seq_2", 64'(pop_log[2]), 64'(32'h40));
    end

    // jar and branch together with a full queue: jar wins
    fixed_lat = 2;
    do_reset();
    wait_head(PCW'(8), "jar_reach8");
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      @(negedge clock);
      if (!imem_req) begin
        found = 1'b1;
        break;
      end
    end
    chk("jar_queue_full", 64'(found), 64'(1));
    pop_log.delete();
    drive(1'b0, 1'b1, PCW'(32'h100), 1'b0, '0, 1'b1, PCW'(32'h80));
    saw_bad = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      if (if_valid && (if_pc == PCW'(10) || if_pc == PCW'(32'h80))) saw_bad = 1'b1;
      idle();
    end
    chk("jar_seen_wrong", 64'(saw_bad), 64'(0));
    chk("jar_log_cnt", 64'(pop_log.size() >= 3), 64'(1));
    if (pop_log.size() >= 3) begin
      chk("jar_seq_0", 64'(pop_log[0]), 64'(8));
      chk("jar_seq_1", 64'(pop_log[1]), 64'(9));
      chk("jar_seq_2", 64'(pop_log[2]), 64'(32'h100));
    end

    // reset while a request is outstanding; late ready must be ignored
    fixed_lat = 3;
    do_reset();
    @(negedge clock);
    chk("rst_outstanding", 64'(imem_req && !imem_ready), 64'(1));
    idle();
    rst = 1'b1;
    force_rdy = 1'b1;
    #1;
    chk("rst_req_drop", 64'(imem_req), 64'(0));
    repeat (2) begin
      @(negedge clock);
      chk("rst_valid", 64'(if_valid), 64'(0));
      chk("rst_req_low", 64'(imem_req), 64'(0));
    end
    rst = 1'b0;
    force_rdy = 1'b0;
    m_exp = '0;
    m_ds = 1'b0;
    pop_log.delete();
    #1;
    chk("rst_restart_addr", 64'(imem_addr), 64'(0));
    chk("rst_restart_req", 64'(imem_req), 64'(1));
    chk("rst_restart_valid", 64'(if_valid), 64'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      idle();
    end
    chk("rst_log_cnt", 64'(pop_log.size() >= 2), 64'(1));
    if (pop_log.size() >= 2) begin
      chk("rst_seq_0", 64'(pop_log[0]), 64'(0));
      chk("rst_seq_1", 64'(pop_log[1]), 64'(1));
    end

    // randomized latency, stalls and redirects against the stream model
    fixed_lat = 0;
    rand_lat = 1'b1;
    do_reset();
    pops = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clock);
      st = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 9) < 2);
      jr = 1'b0; jp = 1'b0; b = 1'b0;
      if (rd && (st || !m_ds)) begin
        jr = 1'($urandom_range(0, 1));
        jp = 1'($urandom_range(0, 1));
        b  = (!jr && !jp) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      drive(st, jr, PCW'($urandom()), jp, PCW'($urandom()), b, PCW'($urandom()));
    end
    chk("rand_progress", 64'(pops > 100), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
